// File: rtl/pmp_match_unit.sv
// One pattern-matching engine: holds a pattern of up to 8 bytes and scans streamed
// data byte-serially, keeping an 8-byte history so matches can span data words.
module pmp_match_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      data,
    input  logic [15:0]      control,
    input  logic             data_ready,
    output logic             data_accepted,
    output logic             pattern_accepted,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, SCAN, ACK} state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_MATCH = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t      state;
    logic [63:0] data_q;
    logic [1:0]  op_q;
    logic [3:0]  n_q;
    logic [2:0]  idx;
    logic [63:0] pattern;
    logic [3:0]  pat_len;
    logic        pat_valid;
    logic [63:0] history;
    logic [3:0]  hist_cnt;

    logic [7:0]  scan_byte;
    logic [63:0] hist_next;
    logic [3:0]  hist_cnt_next;
    logic        match_hit;
    logic [63:0] load_pat;
    logic [2:0]  hpos;

    // History byte 0 is the newest; pattern byte 0 is the oldest of the match window.
    always_comb begin
        hpos          = '0;
        scan_byte     = data_q[{idx, 3'b000} +: 8];
        hist_next     = {history[55:0], scan_byte};
        hist_cnt_next = (hist_cnt == 4'd8) ? 4'd8 : hist_cnt + 4'd1;
        match_hit     = pat_valid && (pat_len != 4'd0) && (hist_cnt_next >= pat_len);
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < pat_len) begin
                hpos = 3'(pat_len - 4'd1 - 4'(j));
                if (hist_next[{hpos, 3'b000} +: 8] != pattern[8*j +: 8])
                    match_hit = 1'b0;
            end
        end
        load_pat = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < n_q)
                load_pat[8*j +: 8] = data_q[8*j +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            data_q           <= '0;
            op_q             <= OP_NOP;
            n_q              <= '0;
            idx              <= '0;
            pattern          <= '0;
            pat_len          <= '0;
            pat_valid        <= 1'b0;
            history          <= '0;
            hist_cnt         <= '0;
            data_accepted    <= 1'b0;
            pattern_accepted <= 1'b0;
            match_count      <= '0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_ready) begin
                        data_q <= data;
                        op_q   <= control[15:14];
                        n_q    <= {1'b0, control[13:11]} + 4'd1;
                        idx    <= '0;
                        case (control[15:14])
                            OP_LOAD, OP_CLEAR: begin
                                state <= EXEC;
                                busy  <= 1'b1;
                            end
                            OP_MATCH: begin
                                state <= SCAN;
                                busy  <= 1'b1;
                            end
                            default: begin
                                state         <= ACK;
                                data_accepted <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (op_q == OP_LOAD) begin
                        pattern   <= load_pat;
                        pat_len   <= n_q;
                        pat_valid <= 1'b1;
                    end else begin
                        pat_valid <= 1'b0;
                    end
                    history          <= '0;
                    hist_cnt         <= '0;
                    match_count      <= '0;
                    pattern_accepted <= 1'b0;
                    busy             <= 1'b0;
                    data_accepted    <= 1'b1;
                    state            <= ACK;
                end
                SCAN: begin
                    history  <= hist_next;
                    hist_cnt <= hist_cnt_next;
                    if (match_hit) begin
                        pattern_accepted <= 1'b1;
                        if (match_count != {CNT_W{1'b1}})
                            match_count <= match_count + 1'b1;
                    end
                    if ({1'b0, idx} == n_q - 4'd1) begin
                        busy          <= 1'b0;
                        data_accepted <= 1'b1;
                        state         <= ACK;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ACK: begin
                    if (!data_ready) begin
                        data_accepted <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
